// File: rtl/bru_pkg.sv
// Shared types and constants for the branch redirect unit: XLEN, branch funct3 codes, FSM states.
package bru_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } bru_state_e;

endpackage : bru_pkg

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation; codes 010/011 are never taken.
module branch_compare
  import bru_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            br_taken
);

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

endmodule : branch_compare

// File: rtl/branch_redirect_unit.sv
// Execute-stage branch/jump resolution, fetch redirect, wrong-path squash and taken counter.
// Optional BRU_MISALIGN_TRAP_EN: misaligned taken targets raise misalign_trap instead of redirecting.
module branch_redirect_unit
  import bru_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ex,
  input  logic             stall_ex,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [XLEN-1:0]  imm_ex,
  output logic             forward_adr_from_ex,
  output logic [XLEN-1:0]  target_pc,
  output logic [XLEN-1:0]  link_addr,
  output logic             kill_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] taken_count
`ifdef BRU_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap
`endif
);

  localparam int unsigned SQ_W = 3;

  bru_state_e        state_q, state_d;
  logic [SQ_W-1:0]   squash_cnt_q, squash_cnt_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic              br_taken;
  logic              taken;
  logic              eligible;
  logic              redirect;
  logic              misaligned;
  logic [XLEN-1:0]   raw_target;

  branch_compare u_branch_compare (
    .funct3   (funct3),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .br_taken (br_taken)
  );

  // JALR outranks JAL, which outranks a conditional branch.
  always_comb begin
    if (is_jalr) begin
      raw_target = (rs1_val + imm_ex) & ~XLEN'(1);
    end else begin
      raw_target = pc_ex + imm_ex;
    end
  end

  assign taken      = is_jalr | is_jal | (is_branch & br_taken);
  assign misaligned = (raw_target[1:0] != 2'b00);
  assign link_addr  = pc_ex + XLEN'(4);

  always_comb begin
    kill_ex             = (state_q == SHADOW) & ~rst;
    eligible            = valid_ex & ~stall_ex & ~kill_ex & ~rst;
`ifdef BRU_MISALIGN_TRAP_EN
    misalign_trap       = eligible & taken & misaligned;
    redirect            = eligible & taken & ~misaligned;
`else
    redirect            = eligible & taken;
`endif
    forward_adr_from_ex = redirect;
    flush_if_id         = redirect;
    flush_id_ex         = redirect;
    target_pc           = rst ? '0 : raw_target;
    taken_count         = taken_count_q;

    state_d       = state_q;
    squash_cnt_d  = squash_cnt_q;
    taken_count_d = taken_count_q;

    if (rst) begin
      state_d       = IDLE;
      squash_cnt_d  = '0;
      taken_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redirect) begin
            state_d       = SHADOW;
            squash_cnt_d  = SQ_W'(SQUASH_DEPTH);
            taken_count_d = taken_count_q + CNT_W'(1);
          end
        end
        SHADOW: begin
          // A stalled EX slot does not advance the wrong-path instruction stream.
          if (!stall_ex) begin
            if (squash_cnt_q <= SQ_W'(1)) begin
              state_d      = IDLE;
              squash_cnt_d = '0;
            end else begin
              squash_cnt_d = squash_cnt_q - SQ_W'(1);
            end
          end
        end
        default: begin
          state_d      = IDLE;
          squash_cnt_d = '0;
        end
      endcase
    end
  end

  // Misalignment only matters when the trap feature is built in.
  logic unused_misaligned;
  assign unused_misaligned = misaligned;

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    squash_cnt_q  <= squash_cnt_d;
    taken_count_q <= taken_count_d;
  end

endmodule : branch_redirect_unit

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit (default SQUASH_DEPTH=2, CNT_W=32).
module tb_branch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        valid_ex;
  logic        stall_ex;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc_ex;
  logic [31:0] imm_ex;
  logic        forward_adr_from_ex;
  logic [31:0] target_pc;
  logic [31:0] link_addr;
  logic        kill_ex;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] taken_count;
`ifdef BRU_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_checks;
  int n_errors;

  branch_redirect_unit #(
    .SQUASH_DEPTH (2),
    .CNT_W        (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_ex            (valid_ex),
    .stall_ex            (stall_ex),
    .is_branch           (is_branch),
    .is_jal              (is_jal),
    .is_jalr             (is_jalr),
    .funct3              (funct3),
    .rs1_val             (rs1_val),
    .rs2_val             (rs2_val),
    .pc_ex               (pc_ex),
    .imm_ex              (imm_ex),
    .forward_adr_from_ex (forward_adr_from_ex),
    .target_pc           (target_pc),
    .link_addr           (link_addr),
    .kill_ex             (kill_ex),
    .flush_if_id         (flush_if_id),
    .flush_id_ex         (flush_id_ex),
    .taken_count         (taken_count)
`ifdef BRU_MISALIGN_TRAP_EN
    ,
    .misalign_trap       (misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let new inputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic stall);
    valid_ex = 1'b1; stall_ex = stall;
    is_branch = 1'b1; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = f3; rs1_val = a; rs2_val = b; pc_ex = pc; imm_ex = imm;
    #1;
  endtask

  task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm);
    valid_ex = 1'b1; stall_ex = 1'b0;
    is_branch = 1'b0; is_jal = 1'b1; is_jalr = 1'b0;
    funct3 = 3'b000; rs1_val = '0; rs2_val = '0; pc_ex = pc; imm_ex = imm;
    #1;
  endtask

  task automatic set_jalr(input logic [31:0] a, input logic [31:0] pc, input logic [31:0] imm);
    valid_ex = 1'b1; stall_ex = 1'b0;
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b1;
    funct3 = 3'b000; rs1_val = a; rs2_val = '0; pc_ex = pc; imm_ex = imm;
    #1;
  endtask

  task automatic set_idle();
    valid_ex = 1'b0; stall_ex = 1'b0;
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; rs1_val = '0; rs2_val = '0; pc_ex = '0; imm_ex = '0;
    #1;
  endtask

  initial begin
    int mis_inc;
`ifdef BRU_MISALIGN_TRAP_EN
    mis_inc = 0;
`else
    mis_inc = 1;
`endif
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_idle();

    // Reset: a JAL on the bus must not redirect while rst is high.
    cyc();
    set_jal(32'h200, 32'h10);
    check("rst_fwd", 32'(forward_adr_from_ex), 32'd0);
    check("rst_target", target_pc, 32'h0);
    check("rst_kill", 32'(kill_ex), 32'd0);
    check("rst_flush", 32'({flush_if_id, flush_id_ex}), 32'd0);
    check("rst_count", taken_count, 32'd0);
    cyc();

    // BEQ taken, then two killed cycles, then BLTU with -1 vs 1 not taken.
    rst = 1'b0;
    set_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    check("beq_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("beq_target", target_pc, 32'h120);
    check("beq_flush", 32'({flush_if_id, flush_id_ex}), 32'd3);
    check("beq_link", link_addr, 32'h104);
    check("beq_kill", 32'(kill_ex), 32'd0);
    cyc();
    check("beq_sh1_kill", 32'(kill_ex), 32'd1);
    check("beq_sh1_fwd", 32'(forward_adr_from_ex), 32'd0);
    check("beq_count", taken_count, 32'd1);
    cyc();
    check("beq_sh2_kill", 32'(kill_ex), 32'd1);
    cyc();
    set_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'hFFFF_FFF0, 1'b0);
    check("bltu_kill", 32'(kill_ex), 32'd0);
    check("bltu_fwd", 32'(forward_adr_from_ex), 32'd0);
    cyc();
    set_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'hFFFF_FFF0, 1'b0);
    check("bltu_count", taken_count, 32'd1);
    check("blt_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("blt_target", target_pc, 32'h2F0);
    cyc();
    set_idle();
    check("blt_count", taken_count, 32'd2);
    cyc(); cyc();

    // JALR clears bit 0 of the computed target.
    set_jalr(32'h1003, 32'h400, 32'h4);
    check("jalr_kill", 32'(kill_ex), 32'd0);
    check("jalr_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("jalr_target", target_pc, 32'h1006);
    check("jalr_link", link_addr, 32'h404);
    cyc();
    set_idle();
    check("jalr_count", taken_count, 32'd3);
    cyc(); cyc();

    // Redirect, then 3 stalled cycles hold the shadow; a taken branch inside is ignored.
    set_jal(32'h500, 32'h40);
    check("stsh_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("stsh_target", target_pc, 32'h540);
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_br(3'b001, 32'd3, 32'd4, 32'h600, 32'h8, 1'b1);
      check($sformatf("stsh_stall%0d_kill", i), 32'(kill_ex), 32'd1);
      check($sformatf("stsh_stall%0d_fwd", i), 32'(forward_adr_from_ex), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      set_br(3'b001, 32'd3, 32'd4, 32'h600, 32'h8, 1'b0);
      check($sformatf("stsh_run%0d_kill", i), 32'(kill_ex), 32'd1);
      check($sformatf("stsh_run%0d_fwd", i), 32'(forward_adr_from_ex), 32'd0);
    end
    cyc();
    set_idle();
    check("stsh_kill_end", 32'(kill_ex), 32'd0);
    check("stsh_count", taken_count, 32'd4);

    // Stalled BNE in IDLE does not redirect; unstalled re-presentation redirects once.
    cyc();
    set_br(3'b001, 32'd3, 32'd4, 32'h600, 32'h8, 1'b1);
    check("bne_stall_fwd", 32'(forward_adr_from_ex), 32'd0);
    cyc();
    set_br(3'b001, 32'd3, 32'd4, 32'h600, 32'h8, 1'b0);
    check("bne_stall_count", taken_count, 32'd4);
    check("bne_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("bne_target", target_pc, 32'h608);
    cyc();
    set_idle();
    check("bne_count", taken_count, 32'd5);
    check("bne_kill", 32'(kill_ex), 32'd1);

    // Reset in the middle of the shadow clears state and counter.
    rst = 1'b1;
    #1;
    check("rstsh_kill", 32'(kill_ex), 32'd0);
    cyc();
    rst = 1'b0;
    set_br(3'b000, 32'd5, 32'd6, 32'h700, 32'h8, 1'b0);
    check("rstsh_kill_after", 32'(kill_ex), 32'd0);
    check("rstsh_count", taken_count, 32'd0);
    check("rstsh_fwd", 32'(forward_adr_from_ex), 32'd0);

    // Funct3 010 never taken even with equal operands.
    cyc();
    set_br(3'b010, 32'd7, 32'd7, 32'h700, 32'h8, 1'b0);
    check("f3_010_fwd", 32'(forward_adr_from_ex), 32'd0);

    // Link wrap with a not-taken branch.
    cyc();
    set_br(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8, 1'b0);
    check("link_wrap", link_addr, 32'h0);

    // JAL target wraps modulo 2^32.
    cyc();
    set_jal(32'hFFFF_FFF0, 32'h20);
    check("jal_wrap_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("jal_wrap_target", target_pc, 32'h10);
    check("jal_wrap_link", link_addr, 32'hFFFF_FFF4);
    cyc();
    set_idle();
    check("jal_wrap_count", taken_count, 32'd1);
    cyc(); cyc();

    // JAL to a halfword-aligned target: redirect by default, trap when the feature is built in.
    set_jal(32'h700, 32'h2);
    check("mis_target", target_pc, 32'h702);
    check("mis_fwd", 32'(forward_adr_from_ex), 32'(mis_inc));
    check("mis_flush", 32'(flush_if_id), 32'(mis_inc));
`ifdef BRU_MISALIGN_TRAP_EN
    check("mis_trap", 32'(misalign_trap), 32'd1);
`endif
    cyc();
    set_idle();
    check("mis_kill", 32'(kill_ex), 32'(mis_inc));
    check("mis_count", taken_count, 32'(1 + mis_inc));
    cyc(); cyc();

    // All three flags set: JALR target wins.
    set_jalr(32'h2000, 32'h800, 32'h11);
    is_jal = 1'b1; is_branch = 1'b1; funct3 = 3'b000; rs2_val = 32'h2000;
    #1;
    check("prio_fwd", 32'(forward_adr_from_ex), 32'd1);
    check("prio_target", target_pc, 32'h2010);
    cyc();
    set_idle();
    check("prio_count", taken_count, 32'(2 + mis_inc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_branch_redirect_unit
